// File: rtl/joypad_input_conditioner.sv
// joypad_input_conditioner: per-channel synchroniser + counter debouncer producing clean levels,
// one-cycle press/release pulses and a valid/ready event stream (channel + direction) for the joypad logic.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   raw_in_i             unsynchronised pin levels (inverted first when ACTIVE_LOW_IN)
//   level_o              debounced level, 1 = pressed
//   press_o, rel_pulse_o one-cycle pulses on accepted 0->1 / 1->0
//   ev_valid_o/ev_ready_i/ev_chan_o/ev_dir_o  event stream, dir 1 = press
//   overflow_o, ov_clear_i  sticky lost-event flag and its clear
// Optional feature: define AUTO_REPEAT_EN to add per-channel auto-repeat presses.
module joypad_input_conditioner #(
  parameter int N_CH            = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW_IN   = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [N_CH-1:0]                        raw_in_i,
  output logic [N_CH-1:0]                        level_o,
  output logic [N_CH-1:0]                        press_o,
  output logic [N_CH-1:0]                        rel_pulse_o,
  output logic                                   ev_valid_o,
  input  logic                                   ev_ready_i,
  output logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0] ev_chan_o,
  output logic                                   ev_dir_o,
  output logic                                   overflow_o,
  input  logic                                   ov_clear_i
);
  localparam int CHW = $clog2(N_CH > 1 ? N_CH : 2);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (N_CH < 1 || N_CH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("joypad_input_conditioner: parameter out of range");
  end

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  s;
  logic [N_CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N_CH-1:0]                  lvl_q, lvl_d, rise, fall, rep, set_p;
  logic [N_CH-1:0]                  press_q, rel_q;
  logic [N_CH-1:0]                  pend_p_q, pend_p_d, pend_r_q, pend_r_d, pend, clr_p, clr_r;
  logic                             ev_valid_q, ev_valid_d, ev_dir_q, ev_dir_d, ov_q, ov_d;
  logic [CHW-1:0]                   ev_chan_q, ev_chan_d, sel;
  logic                             found, sel_dir, load, ovf;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in_i ^ {N_CH{ACTIVE_LOW_IN}}};
  assign s      = sync_q[SYNC_STAGES-1];

  // Counter runs only while the synchronised input disagrees with the accepted level;
  // any agreement (a glitch back) restarts it from zero.
  for (genvar c = 0; c < N_CH; c++) begin : g_db
    assign cnt_d[c] = (s[c] != lvl_q[c] && cnt_q[c] != CNT_LAST) ? cnt_q[c] + 1'b1 : '0;
    assign lvl_d[c] = (s[c] != lvl_q[c] && cnt_q[c] == CNT_LAST) ? s[c] : lvl_q[c];
  end

  assign rise = lvl_d & ~lvl_q;
  assign fall = ~lvl_d & lvl_q;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) > 0 ? $clog2(RMAX) : 1;
  logic [N_CH-1:0][RW-1:0] rcnt_q, rcnt_d;
  logic [N_CH-1:0]         rph_q, rph_d, rhit;
  // rph selects the target: initial delay first, then the repeat period.
  for (genvar c = 0; c < N_CH; c++) begin : g_rep
    assign rhit[c]   = rcnt_q[c] == (rph_q[c] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
    assign rep[c]    = lvl_q[c] & lvl_d[c] & rhit[c];
    assign rcnt_d[c] = (!lvl_q[c] || rhit[c]) ? '0 : rcnt_q[c] + 1'b1;
    assign rph_d[c]  = lvl_q[c] & (rph_q[c] | rhit[c]);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rcnt_q <= '0;
      rph_q  <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      rph_q  <= rph_d;
    end
`else
  assign rep = '0;
`endif

  assign set_p = rise | rep;
  assign pend  = pend_p_q | pend_r_q;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pend[i]) begin
        found = 1'b1;
        sel   = CHW'(i);
      end
  end

  // With both directions pending, a currently released channel must have been pressed first.
  assign sel_dir    = (pend_p_q[sel] & pend_r_q[sel]) ? ~lvl_q[sel] : pend_p_q[sel];
  assign load       = ~ev_valid_q | ev_ready_i;
  assign clr_p      = (load & found & sel_dir) ? N_CH'(1) << sel : '0;
  assign clr_r      = (load & found & ~sel_dir) ? N_CH'(1) << sel : '0;
  assign pend_p_d   = (pend_p_q & ~clr_p) | set_p;
  assign pend_r_d   = (pend_r_q & ~clr_r) | fall;
  assign ovf        = |((set_p & pend_p_q & ~clr_p) | (fall & pend_r_q & ~clr_r));
  assign ov_d       = ovf | (ov_q & ~ov_clear_i);
  assign ev_valid_d = load ? found : ev_valid_q;
  assign ev_chan_d  = (load & found) ? sel : ev_chan_q;
  assign ev_dir_d   = (load & found) ? sel_dir : ev_dir_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      pend_p_q   <= '0;
      pend_r_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_chan_q  <= '0;
      ev_dir_q   <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      press_q    <= set_p;
      rel_q      <= fall;
      pend_p_q   <= pend_p_d;
      pend_r_q   <= pend_r_d;
      ev_valid_q <= ev_valid_d;
      ev_chan_q  <= ev_chan_d;
      ev_dir_q   <= ev_dir_d;
      ov_q       <= ov_d;
    end

  assign level_o     = lvl_q;
  assign press_o     = press_q;
  assign rel_pulse_o = rel_q;
  assign ev_valid_o  = ev_valid_q;
  assign ev_chan_o   = ev_chan_q;
  assign ev_dir_o    = ev_dir_q;
  assign overflow_o  = ov_q;
endmodule

// File: tb/tb_joypad_input_conditioner.sv
// tb_joypad_input_conditioner: scenario tasks plus randomized run against a behavioural model.
module tb_joypad_input_conditioner;
  localparam int N  = 8;
  localparam int SY = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] raw = '0;
  logic       ready = 1'b1;
  logic       ov_clear = 1'b0;
  logic [7:0] level, press, rel;
  logic       ev_valid, ev_dir, overflow;
  logic [2:0] ev_chan;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  joypad_input_conditioner #(
    .N_CH(N), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW_IN(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .raw_in_i(raw), .level_o(level), .press_o(press),
    .rel_pulse_o(rel), .ev_valid_o(ev_valid), .ev_ready_i(ready), .ev_chan_o(ev_chan),
    .ev_dir_o(ev_dir), .overflow_o(overflow), .ov_clear_i(ov_clear)
  );

  // Behavioural model: h[k] is the pin value sampled k+1 edges ago; a level flips once the
  // synchronised value seen on each of the last DB edges disagreed with it.
  typedef struct packed {
    logic [15:0][7:0] h;
    logic [7:0]       lvl, prs, rel, pp, pr;
    logic [7:0][31:0] held;
    logic             ev_v;
    logic [2:0]       ev_c;
    logic             ev_d;
    logic             ov;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t nxt(mdl_t c, logic [7:0] r, logic rdy, logic clr);
    mdl_t n;
    logic tog, dir;
    int   sel;
    n = c;
    for (int i = 0; i < N; i++) begin
      tog = 1'b1;
      for (int j = 0; j < DB; j++) if (c.h[SY-1+j][i] == c.lvl[i]) tog = 1'b0;
      n.lvl[i]  = c.lvl[i] ^ tog;
      n.prs[i]  = tog & ~c.lvl[i];
      n.rel[i]  = tog & c.lvl[i];
      n.held[i] = (c.lvl[i] && n.lvl[i]) ? c.held[i] + 32'd1 : 32'd0;
`ifdef AUTO_REPEAT_EN
      if (c.lvl[i] && n.lvl[i] && n.held[i] >= RD && (n.held[i] - RD) % RP == 0) n.prs[i] = 1'b1;
`endif
    end
    n.h[0] = r;
    for (int k = 1; k < 16; k++) n.h[k] = c.h[k-1];
    n.ov = c.ov & ~clr;
    if (!c.ev_v || rdy) begin
      sel = -1;
      for (int i = N - 1; i >= 0; i--) if (c.pp[i] || c.pr[i]) sel = i;
      n.ev_v = (sel >= 0);
      if (sel >= 0) begin
        dir    = (c.pp[sel] && c.pr[sel]) ? ~c.lvl[sel] : c.pp[sel];
        n.ev_c = 3'(sel);
        n.ev_d = dir;
        if (dir) n.pp[sel] = 1'b0;
        else n.pr[sel] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (n.prs[i]) begin
        if (n.pp[i]) n.ov = 1'b1;
        n.pp[i] = 1'b1;
      end
      if (n.rel[i]) begin
        if (n.pr[i]) n.ov = 1'b1;
        n.pr[i] = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= '0;
    else m <= nxt(m, raw, ready, ov_clear);

  task automatic do_reset();
    rst_n = 1'b0;
    raw = '0;
    ready = 1'b1;
    ov_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw = 8'hFF;
    ready = 1'b1;
    ov_clear = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 8'h00 || press !== 8'h00 || rel !== 8'h00 || ev_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%h press=%h rel=%h ev_valid=%b overflow=%b, required all zero",
               level, press, rel, ev_valid, overflow);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (level !== (c >= 6 ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL reset_level cycle %0d: got %h required %h", c, level, (c >= 6 ? 8'hFF : 8'h00));
      end
      checks++;
      if (press !== (c == 6 ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL reset_press cycle %0d: got %h required %h", c, press, (c == 6 ? 8'hFF : 8'h00));
      end
      checks++;
      if (ev_valid !== (c >= 7 && c <= 14)) begin
        errors++;
        $display("FAIL reset_ev_valid cycle %0d: got %b required %b", c, ev_valid, (c >= 7 && c <= 14));
      end
      if (c >= 7 && c <= 14) begin
        checks++;
        if (ev_chan !== 3'(c - 7) || ev_dir !== 1'b1) begin
          errors++;
          $display("FAIL reset_event cycle %0d: chan=%0d dir=%b required chan=%0d dir=1", c, ev_chan, ev_dir, c - 7);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int npress, nev;
    npress = 0;
    nev = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      raw[3] = (k < 20) ? (k % 4 < 2) : 1'b1;
      @(negedge clk);
      checks++;
      if (level !== (k >= 25 ? 8'h08 : 8'h00)) begin
        errors++;
        $display("FAIL bounce_level k=%0d: got %h required %h", k, level, (k >= 25 ? 8'h08 : 8'h00));
      end
      npress += int'(press[3]);
      if (ev_valid) begin
        nev++;
        checks++;
        if (ev_chan !== 3'd3 || ev_dir !== 1'b1 || k != 26) begin
          errors++;
          $display("FAIL bounce_event k=%0d: chan=%0d dir=%b required chan=3 dir=1 at k=26", k, ev_chan, ev_dir);
        end
      end
    end
    checks++;
    if (npress != 1 || nev != 1) begin
      errors++;
      $display("FAIL bounce_count: presses=%0d events=%0d required 1 and 1", npress, nev);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    raw[5] = 1'b1;
    repeat (3) @(negedge clk);
    raw[2] = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (ev_valid !== 1'b1 || ev_chan !== 3'd5 || ev_dir !== 1'b1) begin
        errors++;
        $display("FAIL hold_ch5 k=%0d: valid=%b chan=%0d dir=%b required 1/5/1", k, ev_valid, ev_chan, ev_dir);
      end
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || ev_chan !== 3'd2 || ev_dir !== 1'b1) begin
      errors++;
      $display("FAIL next_ch2: valid=%b chan=%0d dir=%b required 1/2/1", ev_valid, ev_chan, ev_dir);
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained_bp: ev_valid=%b required 0", ev_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ready = 1'b0;
    raw[7] = 1'b1;
    repeat (8) @(negedge clk);
    raw[1] = 1'b1;
    repeat (8) @(negedge clk);
    raw[1] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || ev_chan !== 3'd7 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL occupied_ch7: valid=%b chan=%0d ovf=%b required 1/7/0", ev_valid, ev_chan, overflow);
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || ev_chan !== 3'd1 || ev_dir !== 1'b1) begin
      errors++;
      $display("FAIL order_press: valid=%b chan=%0d dir=%b required 1/1/1", ev_valid, ev_chan, ev_dir);
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || ev_chan !== 3'd1 || ev_dir !== 1'b0) begin
      errors++;
      $display("FAIL order_release: valid=%b chan=%0d dir=%b required 1/1/0", ev_valid, ev_chan, ev_dir);
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_drained: ev_valid=%b required 0", ev_valid);
    end
    ready = 1'b0;
    raw[6] = 1'b1;
    repeat (8) @(negedge clk);
    raw[1] = 1'b1;
    repeat (8) @(negedge clk);
    raw[1] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || ev_chan !== 3'd6) begin
      errors++;
      $display("FAIL pre_overflow: ovf=%b chan=%0d required 0/6", overflow, ev_chan);
    end
    raw[1] = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b required 1", overflow);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b required 1", overflow);
    end
    ov_clear = 1'b1;
    @(negedge clk);
    ov_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 1'b0;
    raw[0] = 1'b1;
    repeat (8) @(negedge clk);
    raw[4] = 1'b1;
    repeat (8) @(negedge clk);
    raw[4] = 1'b0;
    repeat (8) @(negedge clk);
    raw[4] = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || overflow !== 1'b1 || level !== 8'h11) begin
      errors++;
      $display("FAIL async_pre: valid=%b ovf=%b level=%h required 1/1/11", ev_valid, overflow, level);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ev_valid !== 1'b0 || level !== 8'h00 || overflow !== 1'b0 || press !== 8'h00) begin
      errors++;
      $display("FAIL async_clear: valid=%b level=%h ovf=%b press=%h required all zero", ev_valid, level, overflow, press);
    end
    raw = '0;
    ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (ev_valid !== 1'b0 || level !== 8'h00 || press !== 8'h00) begin
        errors++;
        $display("FAIL async_quiet k=%0d: valid=%b level=%h press=%h required zero", k, ev_valid, level, press);
      end
    end
  endtask

  task automatic test_auto_repeat();
    int t, npost;
    int got[$];
    int expq[$];
    t = 0;
    npost = 0;
    do_reset();
    raw[0] = 1'b1;
    while (!level[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != 6) begin
      errors++;
      $display("FAIL repeat_rise: level rose after %0d cycles required 6", t);
    end
    for (int k = 0; k < 40; k++) begin
      if (press[0]) got.push_back(k);
      @(negedge clk);
    end
    raw[0] = 1'b0;
    expq.push_back(0);
`ifdef AUTO_REPEAT_EN
    for (int k = RD; k < 40; k += RP) expq.push_back(k);
`endif
    checks++;
    if (got.size() != expq.size()) begin
      errors++;
      $display("FAIL repeat_count: got %0d pulses required %0d", got.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got[i] != expq[i]) begin
          errors++;
          $display("FAIL repeat_offset %0d: got +%0d required +%0d", i, got[i], expq[i]);
        end
      end
    end
    t = 0;
    while (level[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      npost += int'(press[0]);
    end
    checks++;
    if (level[0] !== 1'b0 || npost != 0) begin
      errors++;
      $display("FAIL repeat_after_release: level=%b presses=%0d required 0/0", level[0], npost);
    end
  endtask

  task automatic test_random();
    int hold[N];
    do_reset();
    foreach (hold[i]) hold[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          raw[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
        end else hold[i]--;
      end
      ready = ($urandom_range(0, 9) < 7);
      ov_clear = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      checks++;
      if ({level, press, rel} !== {m.lvl, m.prs, m.rel}) begin
        errors++;
        $display("FAIL rand_levels cyc=%0d: level/press/rel=%h/%h/%h required %h/%h/%h",
                 cyc, level, press, rel, m.lvl, m.prs, m.rel);
      end
      checks++;
      if (ev_valid !== m.ev_v || overflow !== m.ov || (m.ev_v && (ev_chan !== m.ev_c || ev_dir !== m.ev_d))) begin
        errors++;
        $display("FAIL rand_event cyc=%0d: valid=%b chan=%0d dir=%b ovf=%b required %b/%0d/%b/%b",
                 cyc, ev_valid, ev_chan, ev_dir, overflow, m.ev_v, m.ev_c, m.ev_d, m.ov);
      end
    end
    ready = 1'b1;
    ov_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_backpressure();
    test_overflow();
    test_async_reset();
    test_auto_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
